// File: rtl/pagerank_iter_sched_if.sv
// Control/status bundle between the PageRank iteration scheduler and its
// gather threads, serializer and host.
interface pagerank_iter_sched_if #(
   parameter int NUM_HW_THREADS = 8
);
   logic                      start;
   logic                      abort;
   logic [7:0]                iter_limit;
   logic [NUM_HW_THREADS-1:0] gather_done;
   logic                      stream_done;
   logic                      gather_go;
   logic                      next_iteration;
   logic [7:0]                iter_count;
   logic                      busy;
   logic                      run_done;
   logic                      error;

   modport master (
      output start, abort, iter_limit, gather_done, stream_done,
      input  gather_go, next_iteration, iter_count, busy, run_done, error
   );

   modport slave (
      input  start, abort, iter_limit, gather_done, stream_done,
      output gather_go, next_iteration, iter_count, busy, run_done, error
   );
endinterface

// File: rtl/pagerank_iter_sched.sv
// Iteration scheduler: sequences gather -> stream -> advance phases for a
// PageRank run, with a per-phase watchdog. All outputs are registered.
module pagerank_iter_sched #(
   parameter int NUM_HW_THREADS = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                  clock,
   input logic                  reset_n,
   pagerank_iter_sched_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_GATHER, S_STREAM, S_ADVANCE, S_FINISH, S_ERROR
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [NUM_HW_THREADS-1:0] done_seen_q, done_seen_d;
   logic [NUM_HW_THREADS-1:0] gather_done;
   logic [15:0]               wd_q, wd_d;
   logic [7:0]                limit_q, limit_d;
   logic [7:0]                iter_count_q, iter_count_d;
   logic                      gather_go_q, gather_go_d;
   logic                      next_iteration_q, next_iteration_d;
   logic                      busy_q, busy_d;
   logic                      run_done_q, run_done_d;
   logic                      error_q, error_d;
   logic                      gather_all;
   logic                      wd_expired;
   logic                      in_phase;

   assign gather_done = bus.gather_done;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // one unassigned, which would infer a latch.
      state_d      = state_q;
      done_seen_d  = done_seen_q;
      limit_d      = limit_q;
      iter_count_d = iter_count_q;
      gather_all   = &(done_seen_q | gather_done);
      wd_expired   = (wd_q == WD_LAST);

      if (bus.abort) begin
         state_d     = S_IDLE;
         done_seen_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d      = S_GATHER;
                  limit_d      = (bus.iter_limit == 8'd0) ? 8'd1 : bus.iter_limit;
                  iter_count_d = 8'd0;
                  done_seen_d  = '0;
               end
            end
            S_GATHER: begin
               done_seen_d = done_seen_q | gather_done;
               // Completion outranks a watchdog expiry landing on the same cycle.
               if (gather_all)      state_d = S_STREAM;
               else if (wd_expired) state_d = S_ERROR;
            end
            S_STREAM: begin
               if (bus.stream_done) state_d = S_ADVANCE;
               else if (wd_expired) state_d = S_ERROR;
            end
            S_ADVANCE: begin
               iter_count_d = iter_count_q + 8'd1;
               done_seen_d  = '0;
               state_d      = (iter_count_d == limit_q) ? S_FINISH : S_GATHER;
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
         endcase
      end

      // Watchdog restarts on every phase entry, including ADVANCE -> GATHER.
      in_phase = (state_d == S_GATHER) || (state_d == S_STREAM);
      wd_d     = (in_phase && (state_d == state_q)) ? wd_q + 16'd1 : 16'd0;

      gather_go_d      = (state_d == S_GATHER) && (state_q != S_GATHER);
      next_iteration_d = (state_d == S_ADVANCE);
      run_done_d       = (state_d == S_FINISH);
      busy_d           = (state_d == S_GATHER) || (state_d == S_STREAM) ||
                         (state_d == S_ADVANCE) || (state_d == S_FINISH);
      error_d          = (state_d == S_ERROR);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q          <= S_IDLE;
         done_seen_q      <= '0;
         wd_q             <= 16'd0;
         limit_q          <= 8'd1;
         iter_count_q     <= 8'd0;
         gather_go_q      <= 1'b0;
         next_iteration_q <= 1'b0;
         busy_q           <= 1'b0;
         run_done_q       <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         done_seen_q      <= done_seen_d;
         wd_q             <= wd_d;
         limit_q          <= limit_d;
         iter_count_q     <= iter_count_d;
         gather_go_q      <= gather_go_d;
         next_iteration_q <= next_iteration_d;
         busy_q           <= busy_d;
         run_done_q       <= run_done_d;
         error_q          <= error_d;
      end
   end

   assign bus.gather_go      = gather_go_q;
   assign bus.next_iteration = next_iteration_q;
   assign bus.iter_count     = iter_count_q;
   assign bus.busy           = busy_q;
   assign bus.run_done       = run_done_q;
   assign bus.error          = error_q;
endmodule

// File: tb/tb_pagerank_iter_sched.sv
// Directed bench for pagerank_iter_sched: a per-cycle vector table plus
// hand sequences for stagger, watchdog, abort and mid-run reset.
module tb_pagerank_iter_sched;
   logic clock = 1'b0;
   logic reset_n;

   pagerank_iter_sched_if #(.NUM_HW_THREADS(8)) bus ();

   pagerank_iter_sched #(
      .NUM_HW_THREADS(8),
      .TIMEOUT_CYCLES(16)
   ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       start;
      logic       abort;
      logic [7:0] lim;
      logic [7:0] gd;
      logic       sd;
      logic       gg;
      logic       ni;
      logic [7:0] ic;
      logic       bsy;
      logic       rd;
      logic       err;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(logic s, logic a, logic [7:0] l, logic [7:0] g, logic sd,
                               logic gg, logic ni, logic [7:0] ic, logic bsy,
                               logic rd, logic err);
      vec_t v;
      v.start = s;  v.abort = a; v.lim = l;   v.gd = g;  v.sd  = sd;
      v.gg    = gg; v.ni    = ni; v.ic = ic; v.bsy = bsy; v.rd = rd; v.err = err;
      return v;
   endfunction

   function automatic logic [12:0] exp_of(logic gg, logic ni, logic [7:0] ic,
                                          logic bsy, logic rd, logic err);
      return {gg, ni, ic, bsy, rd, err};
   endfunction

   function automatic logic [12:0] outs();
      return {bus.gather_go, bus.next_iteration, bus.iter_count,
              bus.busy, bus.run_done, bus.error};
   endfunction

   // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
   task automatic apply(input logic s, input logic a, input logic [7:0] l,
                        input logic [7:0] g, input logic sd);
      @(negedge clock);
      bus.start       = s;
      bus.abort       = a;
      bus.iter_limit  = l;
      bus.gather_done = g;
      bus.stream_done = sd;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {gg,ni,ic,busy,rd,err}=%b_%b_%h_%b_%b_%b expected %b_%b_%h_%b_%b_%b",
                  name, act[12], act[11], act[10:3], act[2], act[1], act[0],
                  exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic step(input string name, input logic s, input logic a, input logic [7:0] l,
                       input logic [7:0] g, input logic sd,
                       input logic gg, input logic ni, input logic [7:0] ic,
                       input logic bsy, input logic rd, input logic err);
      apply(s, a, l, g, sd);
      check(name, outs(), exp_of(gg, ni, ic, bsy, rd, err));
   endtask

   initial begin
      reset_n         = 1'b0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.iter_limit  = 8'd0;
      bus.gather_done = 8'h00;
      bus.stream_done = 1'b0;

      // Two-iteration run, then abort-vs-start in IDLE, then limit 0 acting as 1.
      vecs.push_back(mk(1,0,8'd2,8'h00,0, 1,0,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'hFF,0, 0,0,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,1, 0,1,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 1,0,8'd1,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'hFF,0, 0,0,8'd1,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd1,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd1,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,1, 0,1,8'd1,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd2,1,1,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd2,0,0,0));
      vecs.push_back(mk(1,1,8'd5,8'h00,0, 0,0,8'd2,0,0,0));
      vecs.push_back(mk(1,0,8'd0,8'h00,0, 1,0,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'hFF,0, 0,0,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,1, 0,1,8'd0,1,0,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd1,1,1,0));
      vecs.push_back(mk(0,0,8'd0,8'h00,0, 0,0,8'd1,0,0,0));
      vecs.push_back(mk(0,0,8'd0,8'hFF,1, 0,0,8'd1,0,0,0));

      step("reset0", 0,0,8'd0,8'h00,0, 0,0,8'd0,0,0,0);
      step("reset1", 0,0,8'd0,8'h00,0, 0,0,8'd0,0,0,0);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].start, vecs[i].abort, vecs[i].lim, vecs[i].gd, vecs[i].sd);
         check($sformatf("vec%0d", i), outs(),
               exp_of(vecs[i].gg, vecs[i].ni, vecs[i].ic, vecs[i].bsy, vecs[i].rd, vecs[i].err));
      end

      // Staggered one-cycle gather pulses; stream_done held early must be ignored.
      step("stag_start", 1,0,8'd1,8'h00,0, 1,0,8'd0,1,0,0);
      for (int i = 0; i < 7; i++) begin
         logic [7:0] g;
         g = 8'(1 << i);
         step($sformatf("stag_t%0d", i), 0,0,8'd0,g,1, 0,0,8'd0,1,0,0);
      end
      step("stag_t7",  0,0,8'd0,8'h80,0, 0,0,8'd0,1,0,0);
      step("stag_adv", 0,0,8'd0,8'h00,1, 0,1,8'd0,1,0,0);
      step("stag_fin", 0,0,8'd0,8'h00,0, 0,0,8'd1,1,1,0);
      step("stag_idl", 0,0,8'd0,8'h00,0, 0,0,8'd1,0,0,0);

      // Watchdog: thread 3 never completes; ERROR after 16 GATHER cycles.
      step("wd_start", 1,0,8'd1,8'h00,0, 1,0,8'd0,1,0,0);
      for (int k = 1; k <= 16; k++) begin
         step($sformatf("wd_cyc%0d", k), 0,0,8'd0,8'hF7,0,
              0,0,8'd0,(k != 16),0,(k == 16));
      end
      step("wd_sticky", 1,0,8'd3,8'hFF,1, 0,0,8'd0,0,0,1);
      step("wd_abort",  0,1,8'd0,8'h00,0, 0,0,8'd0,0,0,0);

      // Completion on the expiry cycle wins over the watchdog.
      step("race_start", 1,0,8'd1,8'h00,0, 1,0,8'd0,1,0,0);
      for (int k = 1; k <= 15; k++) begin
         step($sformatf("race_cyc%0d", k), 0,0,8'd0,8'h00,0, 0,0,8'd0,1,0,0);
      end
      step("race_done", 0,0,8'd0,8'hFF,0, 0,0,8'd0,1,0,0);
      step("race_adv",  0,0,8'd0,8'h00,1, 0,1,8'd0,1,0,0);
      step("race_fin",  0,0,8'd0,8'h00,0, 0,0,8'd1,1,1,0);
      step("race_idl",  0,0,8'd0,8'h00,0, 0,0,8'd1,0,0,0);

      // start held throughout; abort coincides with stream_done.
      step("ab_start",  1,0,8'd3,8'h00,0, 1,0,8'd0,1,0,0);
      step("ab_strm",   1,0,8'd3,8'hFF,0, 0,0,8'd0,1,0,0);
      step("ab_hold",   1,0,8'd3,8'h00,0, 0,0,8'd0,1,0,0);
      step("ab_abort",  1,1,8'd3,8'h00,1, 0,0,8'd0,0,0,0);
      step("ab_restrt", 1,0,8'd3,8'h00,0, 1,0,8'd0,1,0,0);
      step("ab_clean",  0,1,8'd0,8'h00,0, 0,0,8'd0,0,0,0);

      // Reset during the second STREAM of a four-iteration run.
      step("rst_start", 1,0,8'd4,8'h00,0, 1,0,8'd0,1,0,0);
      step("rst_s0",    0,0,8'd0,8'hFF,0, 0,0,8'd0,1,0,0);
      step("rst_adv0",  0,0,8'd0,8'h00,1, 0,1,8'd0,1,0,0);
      step("rst_g1",    0,0,8'd0,8'h00,0, 1,0,8'd1,1,0,0);
      step("rst_s1",    0,0,8'd0,8'hFF,0, 0,0,8'd1,1,0,0);
      reset_n = 1'b0;
      step("rst_hit",   0,0,8'd0,8'h00,1, 0,0,8'd0,0,0,0);
      reset_n = 1'b1;
      step("rst_quiet0", 0,0,8'd0,8'h00,1, 0,0,8'd0,0,0,0);
      step("rst_quiet1", 0,0,8'd0,8'h00,0, 0,0,8'd0,0,0,0);
      step("rst_fresh",  1,0,8'd1,8'h00,0, 1,0,8'd0,1,0,0);
      step("rst_fs",     0,0,8'd0,8'hFF,0, 0,0,8'd0,1,0,0);
      step("rst_fadv",   0,0,8'd0,8'h00,1, 0,1,8'd0,1,0,0);
      step("rst_ffin",   0,0,8'd0,8'h00,0, 0,0,8'd1,1,1,0);
      step("rst_fidl",   0,0,8'd0,8'h00,0, 0,0,8'd1,0,0,0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
